// File: rtl/shift_pc_if.sv
// Bundle of the jump-target generator's data signals.
// The master drives the PC/index fields, and the slave returns the jump targets.
interface shift_pc_if;
  logic [3:0]  PC;
  logic [25:0] A;
  logic        in_vld;
  logic [31:0] S;
  logic [31:0] S_q;
  logic        S_q_vld;

  modport master (
    output PC, A, in_vld,
    input  S, S_q, S_q_vld
  );

  modport slave (
    input  PC, A, in_vld,
    output S, S_q, S_q_vld
  );
endinterface

// File: rtl/shift_pc.sv
// MIPS J/JAL target generator: {PC[31:28], index, 2'b00}.
// It has a combinational target and an optional registered copy with a valid flag.
module shift_pc #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  shift_pc_if.slave  bus
);

  logic [31:0] target;

  // This is pure concatenation, so the target never leaves the current 256 MB region.
  assign target = {bus.PC, bus.A, 2'b00};
  assign bus.S  = target;

  generate
    if (OUT_REG) begin : g_reg
      logic [31:0] s_q_reg;
      logic        s_q_vld_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          s_q_reg     <= 32'h0;
          s_q_vld_reg <= 1'b0;
        end else if (bus.in_vld) begin
          s_q_reg     <= target;
          s_q_vld_reg <= 1'b1;
        end else begin
          // Keep the last target readable but mark it stale.
          s_q_vld_reg <= 1'b0;
        end
      end

      assign bus.S_q     = s_q_reg;
      assign bus.S_q_vld = s_q_vld_reg;
    end else begin : g_noreg
      assign bus.S_q     = 32'h0;
      assign bus.S_q_vld = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_shift_pc.sv
// Scoreboard bench for shift_pc, using directed vectors followed by randomized traffic.
module tb_shift_pc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_pc_if bus ();

  shift_pc #(.OUT_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          id;
    logic        rst;
    logic        vld;
    logic [3:0]  pc;
    logic [25:0] a;
    logic [31:0] exp_s;
    logic [31:0] exp_q;
    logic        exp_qv;
  } txn_t;

  txn_t exp_fifo[$];
  int   checks   = 0;
  int   failures = 0;
  bit   pending_valid = 1'b0;
  txn_t pending;

  // This is the reference model state: what S_q should hold after the sampled edge.
  logic [31:0] model_q   = 32'h0;
  logic        model_qv  = 1'b0;
  int          txn_count = 0;

  task automatic issue(input logic r, input logic v, input logic [3:0] pc, input logic [25:0] a);
    txn_t t;
    longint unsigned tgt;
    @(posedge clk);
    #1;
    rst        = r;
    bus.in_vld = v;
    bus.PC     = pc;
    bus.A      = a;
    // The target is the region base plus the word index times four.
    tgt = longint'(pc) * 64'd268435456 + longint'(a) * 64'd4;
    if (!r) begin
      model_q  = 32'h0;
      model_qv = 1'b0;
    end else if (v) begin
      model_q  = tgt[31:0];
      model_qv = 1'b1;
    end else begin
      model_qv = 1'b0;
    end
    t.id     = txn_count;
    t.rst    = r;
    t.vld    = v;
    t.pc     = pc;
    t.a      = a;
    t.exp_s  = tgt[31:0];
    t.exp_q  = model_q;
    t.exp_qv = model_qv;
    exp_fifo.push_back(t);
    txn_count++;
  endtask

  // The monitor checks the registered result of the previous transaction, then the combinational result of the current one.
  initial begin
    forever begin
      @(negedge clk);
      if (pending_valid) begin
        checks += 2;
        if (bus.S_q !== pending.exp_q) begin
          failures++;
          $display("FAIL s_q txn=%0d got=%h want=%h", pending.id, bus.S_q, pending.exp_q);
        end
        if (bus.S_q_vld !== pending.exp_qv) begin
          failures++;
          $display("FAIL s_q_vld txn=%0d got=%b want=%b", pending.id, bus.S_q_vld, pending.exp_qv);
        end
        $display("txn %0d rst=%b vld=%b PC=%h A=%h S_q=%h S_q_vld=%b", pending.id, pending.rst,
                 pending.vld, pending.pc, pending.a, bus.S_q, bus.S_q_vld);
        pending_valid = 1'b0;
      end
      if (exp_fifo.size() > 0) begin
        pending = exp_fifo.pop_front();
        pending_valid = 1'b1;
        checks += 2;
        if (bus.S !== pending.exp_s) begin
          failures++;
          $display("FAIL s_comb txn=%0d got=%h want=%h", pending.id, bus.S, pending.exp_s);
        end
        if (bus.S[1:0] !== 2'b00) begin
          failures++;
          $display("FAIL s_align txn=%0d got=%b want=00", pending.id, bus.S[1:0]);
        end
      end
    end
  end

  initial begin
    bit drained;
    bus.in_vld = 1'b1;
    bus.PC     = 4'h3;
    bus.A      = 26'h0000010;

    // Reset for two edges while in_vld is high.
    issue(1'b0, 1'b1, 4'h3, 26'h0000010);
    issue(1'b0, 1'b1, 4'h3, 26'h0000010);
    issue(1'b1, 1'b1, 4'h3, 26'h0000010);
    issue(1'b1, 1'b0, 4'h7, 26'h2345678);
    issue(1'b1, 1'b1, 4'hA, 26'h1555555);
    issue(1'b0, 1'b1, 4'hF, 26'h3FFFFFF);
    issue(1'b1, 1'b1, 4'h0, 26'h0000001);
    issue(1'b1, 1'b1, 4'hF, 26'h3FFFFFF);
    issue(1'b1, 1'b1, 4'h4, 26'h0100000);
    issue(1'b1, 1'b0, 4'hF, 26'h0000000);
    issue(1'b1, 1'b1, 4'hF, 26'h0000000);
    issue(1'b1, 1'b1, 4'h0, 26'h0000000);
    issue(1'b1, 1'b1, 4'h5, 26'h2AAAAAA);
    issue(1'b1, 1'b0, 4'h0, 26'h0000000);

    for (int i = 0; i < 300; i++) begin
      issue(($urandom % 16) != 0, $urandom_range(0, 1) == 1,
            4'($urandom), 26'($urandom));
    end

    // Let the monitor drain, with a bound on the wait.
    drained = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      if (exp_fifo.size() == 0 && !pending_valid) begin
        drained = 1'b1;
        break;
      end
    end
    checks++;
    if (!drained) begin
      failures++;
      $display("FAIL drain got=%0d_left want=0_left", exp_fifo.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
